// File: rtl/aes_key_schedule_if.sv
// Key-schedule bus: key load handshake, round key read port and status flags.
interface aes_key_schedule_if;
  logic         start;
  logic [0:127] key_in;
  logic [3:0]   round_idx;
  logic [0:127] round_key;
  logic         busy;
  logic         ready;

  // Consumer side: loads a key and reads round keys back.
  modport master (
    output start, key_in, round_idx,
    input  round_key, busy, ready
  );

  // Key schedule side.
  modport slave (
    input  start, key_in, round_idx,
    output round_key, busy, ready
  );
endinterface

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: one round key per clock into an 11-entry key store,
// read combinationally by round index.
module aes_key_schedule (
  input logic              clk,
  input logic              reset,
  aes_key_schedule_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t       state;
  logic [3:0]   rnd;
  logic [7:0]   rcon;
  logic         busy_q;
  logic         ready_q;
  logic [0:127] rk [11];
  logic [0:127] prev_rk;
  logic [0:127] next_rk;
  logic [0:127] round_key_c;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Algebraic S-box: multiplicative inverse as a^254 (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    x2   = gf_mul(a, a);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                  gf_mul(gf_mul(x32, x64), x128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Next round key derived from the previously stored one.
  always_comb begin
    logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;
    prev_rk = '0;
    if (rnd >= 4'd1 && rnd <= 4'd10) prev_rk = rk[rnd - 4'd1];
    w0   = prev_rk[0:31];
    w1   = prev_rk[32:63];
    w2   = prev_rk[64:95];
    w3   = prev_rk[96:127];
    temp = sub_word(rot_word(w3)) ^ {rcon, 24'h0};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    next_rk = {n0, n1, n2, n3};
  end

  // Control FSM and key store; busy/ready are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rnd     <= '0;
      rcon    <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      for (int unsigned i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            rk[0]   <= bus.key_in;
            rnd     <= 4'd1;
            rcon    <= 8'h01;
            state   <= EXPAND;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        EXPAND: begin
          rk[rnd] <= next_rk;
          rcon    <= xtime(rcon);
          rnd     <= rnd + 4'd1;
          if (rnd == 4'd10) begin
            state   <= DONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency read port; indices past round 10 read as zero.
  always_comb begin
    round_key_c = '0;
    if (bus.round_idx <= 4'd10) round_key_c = rk[bus.round_idx];
  end

  assign bus.round_key = round_key_c;
  assign bus.busy      = busy_q;
  assign bus.ready     = ready_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: expected round keys are queued when
// a key is started and compared once the schedule reports ready.
module tb_aes_key_schedule;

  logic clk;
  logic reset;
  aes_key_schedule_if bus ();

  aes_key_schedule dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [0:127] key;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [0:127] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] ZERO_KEY = 128'h0;

  task automatic push_exp(input logic [3:0] idx, input logic [0:127] key);
    exp_t e;
    e.idx = idx;
    e.key = key;
    sb.push_back(e);
  endtask

  task automatic push_fips();
    push_exp(4'd0,  FIPS_KEY);
    push_exp(4'd1,  128'ha0fafe1788542cb123a339392a6c7605);
    push_exp(4'd2,  128'hf2c295f27a96b9435935807a7359f67f);
    push_exp(4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b);
    push_exp(4'd4,  128'hef44a541a8525b7fb671253bdb0bad00);
    push_exp(4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc);
    push_exp(4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd);
    push_exp(4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f);
    push_exp(4'd8,  128'head27321b58dbad2312bf5607f8d292f);
    push_exp(4'd9,  128'hac7766f319fadc2128d12941575c006e);
    push_exp(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    push_exp(4'd13, 128'h0);
  endtask

  task automatic push_zero();
    push_exp(4'd0,  ZERO_KEY);
    push_exp(4'd1,  128'h62636363626363636263636362636363);
    push_exp(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    push_exp(4'd11, 128'h0);
    push_exp(4'd15, 128'h0);
  endtask

  // Pulse start with key, optionally pulse start again with glitch_key at EXPAND
  // cycle glitch_at, and watch busy/ready/round_key[13] until ready rises.
  task automatic run_expansion(input logic [0:127] key, input string tag,
                               input int glitch_at, input logic [0:127] glitch_key);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.key_in    = key;
    bus.round_idx = 4'd13;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.key_in = {$urandom, $urandom, $urandom, $urandom};
    n_checks++;
    if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_start_flags: busy=%b ready=%b, required busy=1 ready=0", tag, bus.busy, bus.ready);
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      bus.start = (c == glitch_at);
      if (c == glitch_at) bus.key_in = glitch_key;
      n_checks++;
      if (bus.round_key !== 128'h0) begin
        n_errors++;
        $display("FAIL %s_idx13_cycle%0d: round_key=%h, required 0", tag, c, bus.round_key);
      end
      if (bus.ready === 1'b1) begin
        lat = c;
        break;
      end
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_errors++;
        $display("FAIL %s_busy_cycle%0d: busy=%b, required 1", tag, c, bus.busy);
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (lat != 10) begin
      n_errors++;
      $display("FAIL %s_latency: ready after %0d cycles (0 = timeout), required 10", tag, lat);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_busy_done: busy=%b, required 0", tag, bus.busy);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.key_in = FIPS_KEY;
    bus.round_idx = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: busy=%b ready=%b, required 0 0", bus.busy, bus.ready);
    end
    push_exp(4'd0, 128'h0);
    push_exp(4'd5, 128'h0);
    push_exp(4'd10, 128'h0);
    push_exp(4'd15, 128'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.round_idx = e.idx;
      #1;
      n_checks++;
      if (bus.round_key !== e.key) begin
        n_errors++;
        $display("FAIL reset_rk%0d: round_key=%h, required %h", e.idx, bus.round_key, e.key);
      end
    end
    reset = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_start_priority: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_fips();
    exp_t e;
    push_fips();
    run_expansion(FIPS_KEY, "fips", 0, '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.round_idx = e.idx;
      #1;
      n_checks++;
      if (bus.round_key !== e.key) begin
        n_errors++;
        $display("FAIL fips_rk%0d: round_key=%h, required %h", e.idx, bus.round_key, e.key);
      end
    end
  endtask

  task automatic test_restart_zero();
    exp_t e;
    push_zero();
    run_expansion(ZERO_KEY, "restart_zero", 0, '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.round_idx = e.idx;
      #1;
      n_checks++;
      if (bus.round_key !== e.key) begin
        n_errors++;
        $display("FAIL restart_zero_rk%0d: round_key=%h, required %h", e.idx, bus.round_key, e.key);
      end
    end
  endtask

  task automatic test_start_during_expand();
    exp_t e;
    push_fips();
    run_expansion(FIPS_KEY, "ignore_start", 4, ZERO_KEY);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.round_idx = e.idx;
      #1;
      n_checks++;
      if (bus.round_key !== e.key) begin
        n_errors++;
        $display("FAIL ignore_start_rk%0d: round_key=%h, required %h", e.idx, bus.round_key, e.key);
      end
    end
  endtask

  task automatic test_reset_mid_expand();
    exp_t e;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.key_in = FIPS_KEY;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_flags: busy=%b ready=%b, required 0 0", bus.busy, bus.ready);
    end
    push_exp(4'd0, 128'h0);
    push_exp(4'd5, 128'h0);
    push_exp(4'd10, 128'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.round_idx = e.idx;
      #1;
      n_checks++;
      if (bus.round_key !== e.key) begin
        n_errors++;
        $display("FAIL mid_reset_rk%0d: round_key=%h, required %h", e.idx, bus.round_key, e.key);
      end
    end
    push_zero();
    run_expansion(ZERO_KEY, "after_reset", 0, '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.round_idx = e.idx;
      #1;
      n_checks++;
      if (bus.round_key !== e.key) begin
        n_errors++;
        $display("FAIL after_reset_rk%0d: round_key=%h, required %h", e.idx, bus.round_key, e.key);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.key_in    = '0;
    bus.round_idx = '0;
    test_reset();
    test_fips();
    test_restart_zero();
    test_start_during_expand();
    test_reset_mid_expand();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
